// File: rtl/inference_sequencer_pkg.sv
// Shared types and helpers for the inference sequencer front end.
// Optional feature macro used by the top: INFERENCE_SEQ_PERF_EN.
package inference_sequencer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;

  localparam int TAG_WIDTH = 4;
  // Widest result word the helpers accept; callers zero-extend into it.
  localparam int RES_MAX_W = 64;

  function automatic logic res_valid_flag(input logic [RES_MAX_W:0] word, input int unsigned dw);
    return |(word & ((RES_MAX_W+1)'(1) << dw));
  endfunction

  function automatic logic [RES_MAX_W:0] res_class(input logic [RES_MAX_W:0] word, input int unsigned dw);
    return word & ~({(RES_MAX_W+1){1'b1}} << dw);
  endfunction

endpackage

// File: rtl/inference_seq_pingpong_buffer.sv
// Two-bank feature store: host fills one bank while the other is streamed out.
// Bank-full flags gate both the write side and the stream start.
module inference_seq_pingpong_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FEATURE_AMOUNT = 4,
  parameter int IDX_W          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_value,
  output logic                  o_wr_ready,
  input  logic [IDX_W-1:0]      i_rd_idx,
  input  logic                  i_rd_done,
  output logic                  o_rd_full,
  output logic [DATA_WIDTH-1:0] o_rd_value
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] r_buf [2][FEATURE_AMOUNT];
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [IDX_W-1:0]      r_wr_idx;
  logic                  r_wr_ready;

  logic                  w_wr_fire;
  logic [1:0]            w_full_nxt;
  logic                  w_wr_bank_nxt;
  logic                  w_rd_bank_nxt;
  logic [IDX_W-1:0]      w_wr_idx_nxt;

  assign w_wr_fire  = i_wr_en && !r_full[r_wr_bank];
  assign o_wr_ready = r_wr_ready;
  assign o_rd_full  = r_full[r_rd_bank];
  assign o_rd_value = r_buf[r_rd_bank][i_rd_idx];

  // Next pointers and flags; write and read banks never coincide while both are active.
  always_comb begin
    w_full_nxt    = r_full;
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_wr_idx_nxt  = r_wr_idx;
    if (w_wr_fire) begin
      if (r_wr_idx == LAST_IDX) begin
        w_wr_idx_nxt          = {IDX_W{1'b0}};
        w_full_nxt[r_wr_bank] = 1'b1;
        w_wr_bank_nxt         = ~r_wr_bank;
      end else begin
        w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
      end
    end else begin
      w_wr_idx_nxt = r_wr_idx;
    end
    if (i_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt         = ~r_rd_bank;
    end else begin
      w_rd_bank_nxt = r_rd_bank;
    end
  end

  // Control state; host_ready is registered from the next-state flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= {IDX_W{1'b0}};
      r_wr_ready <= 1'b1;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_wr_ready <= !w_full_nxt[w_wr_bank_nxt];
    end
  end

  // Data storage needs no reset: contents are only read behind a full flag.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_buf[r_wr_bank][r_wr_idx] <= i_wr_value;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Feeds buffered feature vectors to layer 1 in bursts under an in-flight credit
// limit and tags returning argmax results. Macro INFERENCE_SEQ_PERF_EN adds latency_cycles.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FEATURE_AMOUNT = 4,
  parameter int MAX_IN_FLIGHT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] host_value,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
  input  logic [DATA_WIDTH:0]   input_result,
  output logic [DATA_WIDTH-1:0] result_class,
  output logic [TAG_WIDTH-1:0]  result_tag,
  output logic                  result_valid,
  output logic [3:0]            in_flight,
  output logic                  error
`ifdef INFERENCE_SEQ_PERF_EN
  ,output logic [15:0]          latency_cycles
`endif
);

  localparam int IDX_W = (FEATURE_AMOUNT > 1) ? $clog2(FEATURE_AMOUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_AMOUNT - 1);

  stream_state_t         r_state;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [DATA_WIDTH-1:0] r_out_index;
  logic [DATA_WIDTH-1:0] r_out_value;
  logic                  r_out_enable;
  logic [DATA_WIDTH-1:0] r_res_class;
  logic [TAG_WIDTH-1:0]  r_res_tag;
  logic [TAG_WIDTH-1:0]  r_ret_tag;
  logic                  r_res_valid;
  logic [3:0]            r_in_flight;
  logic                  r_error;

  stream_state_t         w_state_nxt;
  logic                  w_emit;
  logic                  w_last;
  logic [IDX_W-1:0]      w_emit_idx;
  logic [IDX_W-1:0]      w_rd_idx_nxt;
  logic                  w_rd_full;
  logic [DATA_WIDTH-1:0] w_rd_value;
  logic                  w_start;
  logic [RES_MAX_W:0]    w_res_word;
  logic                  w_res_v;
  logic                  w_retire;
  logic [3:0]            w_in_flight_nxt;

  inference_seq_pingpong_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .FEATURE_AMOUNT(FEATURE_AMOUNT),
    .IDX_W         (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (host_valid),
    .i_wr_value(host_value),
    .o_wr_ready(host_ready),
    .i_rd_idx  (w_emit_idx),
    .i_rd_done (w_last),
    .o_rd_full (w_rd_full),
    .o_rd_value(w_rd_value)
  );

  assign w_start    = w_rd_full && (r_in_flight < 4'(MAX_IN_FLIGHT));
  assign w_res_word = (RES_MAX_W+1)'(input_result);
  assign w_res_v    = res_valid_flag(w_res_word, DATA_WIDTH);
  assign w_retire   = w_res_v && (r_in_flight != 4'd0);

  // Index 0 is emitted straight from IDLE, so a ready sample that follows a
  // finished burst continues with no gap.
  always_comb begin
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_emit_idx   = r_rd_idx;
    w_rd_idx_nxt = r_rd_idx;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_emit     = 1'b1;
          w_emit_idx = {IDX_W{1'b0}};
        end else begin
          w_emit = 1'b0;
        end
      end
      ST_STREAM: begin
        w_emit     = 1'b1;
        w_emit_idx = r_rd_idx;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_last = w_emit && (w_emit_idx == LAST_IDX);
    if (w_last) begin
      w_state_nxt  = ST_IDLE;
      w_rd_idx_nxt = {IDX_W{1'b0}};
    end else if (w_emit) begin
      w_state_nxt  = ST_STREAM;
      w_rd_idx_nxt = w_emit_idx + IDX_W'(1);
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Credit count: a simultaneous issue and retire leaves it unchanged.
  always_comb begin
    w_in_flight_nxt = r_in_flight;
    case ({w_last, w_retire})
      2'b10:   w_in_flight_nxt = r_in_flight + 4'd1;
      2'b01:   w_in_flight_nxt = r_in_flight - 4'd1;
      default: w_in_flight_nxt = r_in_flight;
    endcase
  end

  // Stream outputs, result port and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_idx     <= {IDX_W{1'b0}};
      r_out_index  <= {DATA_WIDTH{1'b0}};
      r_out_value  <= {DATA_WIDTH{1'b0}};
      r_out_enable <= 1'b0;
      r_res_class  <= {DATA_WIDTH{1'b0}};
      r_res_tag    <= {TAG_WIDTH{1'b0}};
      r_ret_tag    <= {TAG_WIDTH{1'b0}};
      r_res_valid  <= 1'b0;
      r_in_flight  <= 4'd0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_out_enable <= w_emit;
      if (w_emit) begin
        r_out_index <= DATA_WIDTH'(w_emit_idx);
        r_out_value <= w_rd_value;
      end
      r_res_valid <= w_retire;
      if (w_retire) begin
        r_res_class <= DATA_WIDTH'(res_class(w_res_word, DATA_WIDTH));
        r_res_tag   <= r_ret_tag;
        r_ret_tag   <= r_ret_tag + TAG_WIDTH'(1);
      end
      r_in_flight <= w_in_flight_nxt;
      if (w_res_v && (r_in_flight == 4'd0)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign output_index  = r_out_index;
  assign output_value  = r_out_value;
  assign output_enable = r_out_enable;
  assign result_class  = r_res_class;
  assign result_tag    = r_res_tag;
  assign result_valid  = r_res_valid;
  assign in_flight     = r_in_flight;
  assign error         = r_error;

`ifdef INFERENCE_SEQ_PERF_EN
  localparam int PTR_W = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;

  logic [15:0]              r_cyc;
  logic [15:0]              r_latency;
  logic [15:0]              r_stamp [MAX_IN_FLIGHT];
  logic [MAX_IN_FLIGHT-1:0] r_ovf;
  logic [PTR_W-1:0]         r_wp;
  logic [PTR_W-1:0]         r_rp;
  logic                     w_push;
  logic [15:0]              w_age;

  assign w_push = w_emit && (w_emit_idx == {IDX_W{1'b0}});
  assign w_age  = r_cyc - r_stamp[r_rp];

  // Timestamp FIFO; an entry whose age passes 16 bits is flagged to saturate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc     <= 16'd0;
      r_latency <= 16'd0;
      r_ovf     <= {MAX_IN_FLIGHT{1'b0}};
      r_wp      <= {PTR_W{1'b0}};
      r_rp      <= {PTR_W{1'b0}};
      for (int i = 0; i < MAX_IN_FLIGHT; i++) r_stamp[i] <= 16'd0;
    end else begin
      r_cyc <= r_cyc + 16'd1;
      for (int i = 0; i < MAX_IN_FLIGHT; i++) begin
        if (r_cyc + 16'd1 == r_stamp[i]) r_ovf[i] <= 1'b1;
      end
      if (w_push) begin
        r_stamp[r_wp] <= r_cyc;
        r_ovf[r_wp]   <= 1'b0;
        r_wp          <= (r_wp == PTR_W'(MAX_IN_FLIGHT - 1)) ? {PTR_W{1'b0}} : r_wp + PTR_W'(1);
      end
      if (w_retire) begin
        r_latency <= r_ovf[r_rp] ? 16'hFFFF : w_age;
        r_rp      <= (r_rp == PTR_W'(MAX_IN_FLIGHT - 1)) ? {PTR_W{1'b0}} : r_rp + PTR_W'(1);
      end
    end
  end

  assign latency_cycles = r_latency;
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed plus randomized bench for inference_sequencer against a queue-based reference model.
module tb_inference_sequencer;

  localparam int DW  = 32;
  localparam int FA  = 4;
  localparam int MIF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] host_value;
  logic          host_valid;
  logic          host_ready;
  logic [DW-1:0] output_index;
  logic [DW-1:0] output_value;
  logic          output_enable;
  logic [DW:0]   input_result;
  logic [DW-1:0] result_class;
  logic [3:0]    result_tag;
  logic          result_valid;
  logic [3:0]    in_flight;
  logic          error;
`ifdef INFERENCE_SEQ_PERF_EN
  logic [15:0]   latency_cycles;
  logic [15:0]   e_lat;
`endif

  always #5 clk = ~clk;

  inference_sequencer #(.DATA_WIDTH(DW), .FEATURE_AMOUNT(FA), .MAX_IN_FLIGHT(MIF)) dut (
`ifdef INFERENCE_SEQ_PERF_EN
    .latency_cycles(latency_cycles),
`endif
    .clk(clk), .rst_n(rst_n), .host_value(host_value), .host_valid(host_valid),
    .host_ready(host_ready), .output_index(output_index), .output_value(output_value),
    .output_enable(output_enable), .input_result(input_result), .result_class(result_class),
    .result_tag(result_tag), .result_valid(result_valid), .in_flight(in_flight), .error(error)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: complete samples waiting or streaming, the partial sample,
  // position inside the running burst, outstanding count and retire tag.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] cur[$];
  int            stamps[$];
  int            pos, m_inflight, m_tag, cyc;
  bit            m_err;
  bit            e_en, e_rv, e_ready, e_all;
  logic [DW-1:0] e_idx, e_val, e_cls;
  logic [3:0]    e_tag;
  int            run, max_run;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit emit, retire, accept;
    int eidx;
    cyc++;
    if (!rst_n) begin
      sq.delete(); cur.delete(); stamps.delete();
      pos = 0; m_inflight = 0; m_tag = 0; m_err = 1'b0;
      e_en = 1'b0; e_rv = 1'b0; e_ready = 1'b1; e_all = 1'b1;
      e_idx = '0; e_val = '0; e_cls = '0; e_tag = '0;
`ifdef INFERENCE_SEQ_PERF_EN
      e_lat = '0;
`endif
      return;
    end
    e_all  = 1'b0;
    accept = host_valid && ((sq.size() / FA) < 2);
    emit   = 1'b0;
    eidx   = 0;
    if (pos > 0) begin
      emit = 1'b1; eidx = pos;
    end else if (sq.size() >= FA && m_inflight < MIF) begin
      emit = 1'b1; eidx = 0;
    end
    retire = input_result[DW] && (m_inflight > 0);
    if (input_result[DW] && m_inflight == 0) m_err = 1'b1;
    e_en = emit;
    e_rv = retire;
    if (emit) begin
      e_idx = eidx;
      e_val = sq[eidx];
      if (eidx == 0) stamps.push_back(cyc);
    end
    if (retire) begin
      int st;
      e_cls = input_result[DW-1:0];
      e_tag = 4'(m_tag % 16);
      m_tag++;
      st = stamps.pop_front();
`ifdef INFERENCE_SEQ_PERF_EN
      e_lat = ((cyc - st) > 65535) ? 16'hFFFF : 16'(cyc - st);
`endif
    end
    if (emit && eidx == FA - 1) begin
      repeat (FA) void'(sq.pop_front());
      pos = 0;
      m_inflight++;
    end else if (emit) begin
      pos = eidx + 1;
    end
    if (retire) m_inflight--;
    if (accept) begin
      cur.push_back(host_value);
      if (cur.size() == FA) begin
        foreach (cur[i]) sq.push_back(cur[i]);
        cur.delete();
      end
    end
    e_ready = (sq.size() / FA) < 2;
  endtask

  task automatic tick();
    logic [3:0] fl;
    model_edge();
    @(posedge clk);
    #1;
    fl = 4'(m_inflight);
    chk("host_ready", 64'(host_ready), 64'(e_ready));
    chk("output_enable", 64'(output_enable), 64'(e_en));
    chk("result_valid", 64'(result_valid), 64'(e_rv));
    chk("in_flight", 64'(in_flight), 64'(fl));
    chk("error", 64'(error), 64'(m_err));
    if (e_en || e_all) begin
      chk("output_index", 64'(output_index), 64'(e_idx));
      chk("output_value", 64'(output_value), 64'(e_val));
    end
    if (e_rv || e_all) begin
      chk("result_class", 64'(result_class), 64'(e_cls));
      chk("result_tag", 64'(result_tag), 64'(e_tag));
`ifdef INFERENCE_SEQ_PERF_EN
      chk("latency_cycles", 64'(latency_cycles), 64'(e_lat));
`endif
    end
    if (output_enable) run++; else run = 0;
    if (run > max_run) max_run = run;
  endtask

  task automatic write_sample(input logic [DW-1:0] v);
    for (int i = 0; i < FA; i++) begin
      host_valid = 1'b1;
      host_value = v;
      tick();
    end
    host_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && (m_inflight > 0 || sq.size() > 0 || pos > 0); k++) begin
      input_result = (m_inflight > 0) ? {1'b1, 32'($urandom())} : '0;
      tick();
    end
    input_result = '0;
    chk("drained", 64'(m_inflight + sq.size() + pos), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; host_valid = 1'b0; host_value = '0; input_result = '0;
    pos = 0; m_inflight = 0; m_tag = 0; cyc = 0; m_err = 1'b0; run = 0; max_run = 0;
    tick(); tick();
    rst_n = 1'b1;

    // Single sample of ones.
    write_sample(32'd1);
    repeat (6) tick();
    chk("t1_in_flight", 64'(in_flight), 64'd1);
    drain();

    // Two samples back-to-back produce one 8-cycle burst.
    max_run = 0;
    for (int i = 0; i < 2 * FA; i++) begin
      host_valid = 1'b1;
      host_value = (i < FA) ? 32'd1 : 32'd2;
      tick();
    end
    host_valid = 1'b0;
    repeat (6) tick();
    chk("t2_burst_len", 64'(max_run), 64'(2 * FA));
    chk("t2_in_flight", 64'(in_flight), 64'd2);

    // Credit exhausted: two more samples fill both banks.
    write_sample(32'd3);
    write_sample(32'd4);
    repeat (4) tick();
    chk("t3_host_ready", 64'(host_ready), 64'd0);
    chk("t3_no_stream", 64'(output_enable), 64'd0);
    input_result = {1'b1, 32'd1};
    tick();
    input_result = '0;
    chk("t3_tag", 64'(result_tag), 64'd1);
    tick();
    chk("t3_restart", 64'(output_enable), 64'd1);
    input_result = {1'b1, 32'd0};
    tick();
    input_result = '0;
    chk("t3_class", 64'(result_class), 64'd0);
    drain();

    // Stray result with nothing outstanding.
    input_result = {1'b1, 32'd7};
    tick();
    input_result = '0;
    chk("err_set", 64'(error), 64'd1);
    chk("err_no_valid", 64'(result_valid), 64'd0);
    repeat (3) tick();
    chk("err_sticky", 64'(error), 64'd1);

    // Reset in the middle of a burst.
    write_sample(32'hA5A5_0001);
    tick(); tick();
    chk("mid_burst", 64'(output_enable), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_enable", 64'(output_enable), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst_n = 1'b1;

    // Random traffic, results only while something is outstanding.
    for (int k = 0; k < 800; k++) begin
      host_valid   = ($urandom_range(0, 3) != 0);
      host_value   = $urandom();
      input_result = (m_inflight > 0 && $urandom_range(0, 2) == 0) ? {1'b1, 32'($urandom())} : '0;
      rst_n        = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; host_valid = 1'b0; input_result = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
